// File: rtl/tone_mapping_ctrl_if.sv
// tone_mapping_ctrl_if: pixel stream bundle (framing, qualifier, data)
interface tone_mapping_ctrl_if #(parameter int W = 10);
   logic sop;
   logic eop;
   logic valid;
   logic [W-1:0] data;
   modport master (output sop, eop, valid, data);
   modport slave (input sop, eop, valid, data);
endinterface

// File: rtl/tone_mapping_ctrl.sv
// tone_mapping_ctrl: per-frame min/max tracker committing clamped (min, range) tone-map parameters
module tone_mapping_ctrl #(
   parameter int W = 10,
   parameter int PIX_W = 22,
   parameter int MIN_RANGE = 16
) (
   input  logic clk,
   input  logic reset_n,
   tone_mapping_ctrl_if.slave pix,
   output logic [W-1:0] min_o,
   output logic [W-1:0] range_o,
   output logic params_upd,
   output logic [15:0] frame_cnt,
   output logic [PIX_W-1:0] pix_cnt_o,
   output logic err_sop,
   output logic err_eop,
   output logic err_orphan,
   output logic busy
);
   localparam logic [W-1:0] MR = W'(MIN_RANGE);
   localparam logic [W-1:0] LIM = {W{1'b1}} - MR;
   typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;
   state_t state, nxt;
   logic [W-1:0] min_acc, max_acc, d;
   logic [PIX_W-1:0] pix_acc;
   logic s_beat, e_beat;
   always_comb begin
      s_beat = pix.valid & pix.sop;
      e_beat = pix.valid & pix.eop;
      d = max_acc - min_acc;
      nxt = (state == ACTIVE || s_beat) ? (e_beat ? COMMIT : ACTIVE) : IDLE;
   end
   // COMMIT cycle behaves as IDLE for incoming beats, so a sop there starts the next frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         min_acc <= '0;
         max_acc <= '0;
         pix_acc <= '0;
         min_o <= '0;
         range_o <= '1;
         params_upd <= 1'b0;
         frame_cnt <= '0;
         pix_cnt_o <= '0;
         err_sop <= 1'b0;
         err_eop <= 1'b0;
         err_orphan <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= nxt;
         busy <= nxt != IDLE;
         params_upd <= state == COMMIT;
         err_sop <= state == ACTIVE && s_beat;
         err_eop <= state != ACTIVE && e_beat && !pix.sop;
         err_orphan <= state != ACTIVE && pix.valid && !pix.sop && !pix.eop;
         if (state == COMMIT) begin
            range_o <= d >= MR ? d : MR;
            min_o <= (d >= MR || min_acc < LIM) ? min_acc : LIM;
            pix_cnt_o <= pix_acc;
            frame_cnt <= frame_cnt + 1'b1;
         end
         if (s_beat) begin
            min_acc <= pix.data;
            max_acc <= pix.data;
            pix_acc <= PIX_W'(1);
         end else if (state == ACTIVE && pix.valid) begin
            min_acc <= pix.data < min_acc ? pix.data : min_acc;
            max_acc <= pix.data > max_acc ? pix.data : max_acc;
            pix_acc <= &pix_acc ? pix_acc : pix_acc + 1'b1;
         end
      end
   end
endmodule

// File: doc/tone_mapping_ctrl.md
# tone_mapping_ctrl

Frame-level controller for the tone-mapping datapath. It watches the pixel stream (sop/eop/valid/data), accumulates per-frame minimum and maximum, and at end of frame commits a clamped (min, range) parameter pair with a one-cycle update strobe. It also checks framing (stray sop/eop, orphan pixels) and keeps frame and pixel counters. It sits alongside the tone-mapping subtract/scale/divide path and supplies that path's offset and denominator once per frame, so the divider never sees a zero or tiny denominator.

## Interface
- W, 10, pixel data width
- PIX_W, 22, pixel counter width
- MIN_RANGE, 16, minimum committed range; must satisfy 1 <= MIN_RANGE < 2^W-1

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- sop  in  1  start of frame, qualified by valid, coincident with the first pixel
- eop  in  1  end of frame, qualified by valid, coincident with the last pixel
- valid  in  1  pixel beat qualifier
- data  in  W  pixel value
- min_o  out  W  committed frame offset (minimum)
- range_o  out  W  committed frame range (max-min, clamped)
- params_upd  out  1  one-cycle pulse when min_o/range_o change
- frame_cnt  out  16  count of committed frames, wraps
- pix_cnt_o  out  PIX_W  pixel count of the last committed frame
- err_sop  out  1  one-cycle pulse: sop while a frame is active
- err_eop  out  1  one-cycle pulse: eop while idle
- err_orphan  out  1  one-cycle pulse: valid non-sop beat while idle
- busy  out  1  high in ACTIVE and COMMIT

## Operation
- A beat is any cycle with valid=1. sop, eop and data are ignored when valid=0.
- FSM states:
  - IDLE -> ACTIVE on a sop beat.
  - IDLE -> COMMIT on a beat with both sop and eop (single-pixel frame).
  - ACTIVE -> COMMIT on an eop beat.
  - ACTIVE -> ACTIVE on a sop beat: restart the frame and pulse err_sop.
  - COMMIT -> IDLE, or COMMIT -> ACTIVE if a sop beat arrives in the COMMIT cycle. That sop is accepted as a new frame and is not an error.
- On a sop beat: min_acc = max_acc = data; pix_acc = 1.
- On other ACTIVE beats: min_acc = min(min_acc, data); max_acc = max(max_acc, data); pix_acc increments and saturates at 2^PIX_W-1.
- The eop beat data is included in the accumulation.
- A sop restart discards the partial frame. frame_cnt does not increment for it and outputs are unchanged.
- COMMIT arithmetic (unsigned, W bits, no overflow since max_acc >= min_acc):
  - d = max_acc - min_acc.
  - If d >= MIN_RANGE: range_o = d, min_o = min_acc.
  - Otherwise: range_o = MIN_RANGE and min_o = min(min_acc, 2^W-1-MIN_RANGE). This keeps min_o+range_o <= 2^W-1.
  - On the same edge: pix_cnt_o = pix_acc; frame_cnt += 1 (0xFFFF wraps to 0); params_upd = 1 for exactly one cycle.
- Error conditions while in IDLE:
  - eop beat without sop: pulse err_eop; it does not start a frame.
  - Non-sop, non-eop beat: pulse err_orphan; the beat is dropped.
- Beats other than sop arriving in the COMMIT cycle are treated as IDLE beats (err_orphan or err_eop).
- Reset, asynchronous, any state:
  - State returns to IDLE and accumulators clear.
  - min_o=0, range_o=2^W-1, params_upd=0, frame_cnt=0, pix_cnt_o=0, all err_*=0, busy=0.
  - A frame in progress at reset is lost. The first full frame after reset commits normally.

## Timing
- The eop beat is sampled at edge E. COMMIT is the cycle after E.
- min_o, range_o, pix_cnt_o and frame_cnt change at edge E+1, with params_upd high during the cycle following E+1. Latency from eop beat to params_upd is 2 cycles.
- Committed outputs hold stable between params_upd pulses. The downstream path samples them on params_upd.
- err_* pulses are registered: high the cycle after the offending beat.
- busy is registered from state: high the cycle after a sop beat and low the cycle after COMMIT if no new sop arrived.
- No backpressure. Every beat is consumed in one cycle, and back-to-back frames with zero gap are supported.

## Test plan
- Frame 100(sop), 50, 700, 300(eop) with W=10 -> min_o=50, range_o=650, pix_cnt_o=4, frame_cnt=1, single params_upd 2 cycles after eop.
- Flat frame of eight beats at 1020 -> range_o=16, min_o=1007. Then a frame at 3, 10 -> min_o=3, range_o=16.
- 10(sop), 20, then 500(sop), 600(eop) -> err_sop one pulse, min_o=500, range_o=100, frame_cnt increments by 1 only.
- Single beat 5 with sop and eop -> min_o=5, range_o=16, pix_cnt_o=1. A stray eop beat then a stray plain beat while idle -> err_eop, then err_orphan, outputs unchanged.
- Back-to-back frames with sop in the COMMIT cycle, and valid=0 cycles carrying data=1023 mid-frame -> both frames commit, the idle garbage is ignored, and no error pulses occur.
- reset_n low mid-frame -> immediate reset values (range_o=1023). The next frame 200, 400 commits min_o=200, range_o=200, frame_cnt=1.
